// File: rtl/conv_counter_ctrl.sv
// conv_counter_ctrl
//   Sequencing controller for the number-conversion display path. Debounces
//   three active-low mode buttons, latches the selected mode (BIN/DEC/HEX),
//   runs a 4-bit counter seeded from the switches and advanced by an internal
//   prescaled tick, and produces registered glyph codes for three digit
//   decoders.
//
// Ports
//   i_clk      system clock, all state on the rising edge
//   i_rst      synchronous reset, active-high
//   i_btn[2:0] raw buttons, active-low: [0]=BIN, [1]=DEC, [2]=HEX
//   i_sw[3:0]  counter seed, sampled only when a new mode is selected
//   o_disp2    glyph code, leftmost digit
//   o_disp1    glyph code, middle digit
//   o_disp0    glyph code, rightmost digit
//   o_mode     0=NONE, 1=BIN, 2=DEC, 3=HEX
//   o_running  counter is advancing
//
// Glyph codes: 0..15 hex digit, 01011 "b", 01101 "d", 10000 "h", 10001 blank.

module conv_counter_ctrl #(
  parameter int DB_CYCLES = 500000,
  parameter int TICK_DIV  = 50000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_btn,
  input  logic [3:0] i_sw,
  output logic [4:0] o_disp2,
  output logic [4:0] o_disp1,
  output logic [4:0] o_disp0,
  output logic [1:0] o_mode,
  output logic       o_running
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int PW  = $clog2(TICK_DIV + 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [PW-1:0]  TICK_LAST = PW'(TICK_DIV - 1);

  localparam logic [4:0] G_B     = 5'b01011;
  localparam logic [4:0] G_D     = 5'b01101;
  localparam logic [4:0] G_H     = 5'b10000;
  localparam logic [4:0] G_BLANK = 5'b10001;
  localparam logic [4:0] G_ONE   = 5'd1;
  localparam logic [4:0] G_NINE  = 5'd9;

  typedef enum logic [1:0] {
    M_NONE = 2'd0,
    M_BIN  = 2'd1,
    M_DEC  = 2'd2,
    M_HEX  = 2'd3
  } mode_t;

  logic [2:0]     r_sync1;
  logic [2:0]     r_sync2;
  logic [2:0]     r_db_lvl;
  logic [DBW-1:0] r_db_cnt [3];

  mode_t          r_state;
  logic           r_running;
  logic [3:0]     r_cnt;
  logic [PW-1:0]  r_presc;

  logic [4:0]     r_disp2;
  logic [4:0]     r_disp1;
  logic [4:0]     r_disp0;

  logic [2:0]     w_press;
  logic           w_any_press;
  mode_t          w_target;
  logic [3:0]     w_cnt_adv;

  // Two-flop synchroniser; released (high) is the reset level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 3'b111;
      r_sync2 <= 3'b111;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Stability counters: the debounced level follows the synchronised level
  // only after DB_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_db_lvl <= 3'b111;
      for (int i = 0; i < 3; i++) begin
        r_db_cnt[i] <= {DBW{1'b0}};
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] != r_db_lvl[i]) begin
          if (r_db_cnt[i] == DB_LAST) begin
            r_db_lvl[i] <= r_sync2[i];
            r_db_cnt[i] <= {DBW{1'b0}};
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + {{(DBW-1){1'b0}}, 1'b1};
          end
        end else begin
          r_db_cnt[i] <= {DBW{1'b0}};
        end
      end
    end
  end

  // Press event fires in the cycle the debounced level falls, so the FSM
  // reacts on the same edge the level is accepted.
  always_comb begin
    w_press = 3'b000;
    for (int i = 0; i < 3; i++) begin
      w_press[i] = r_db_lvl[i] & ~r_sync2[i] & (r_db_cnt[i] == DB_LAST);
    end
  end

  // Priority select among simultaneous presses: HEX > DEC > BIN.
  always_comb begin
    w_any_press = |w_press;
    if (w_press[2]) begin
      w_target = M_HEX;
    end else if (w_press[1]) begin
      w_target = M_DEC;
    end else begin
      w_target = M_BIN;
    end
  end

  // Next counter value on a tick; BIN wraps at 9 (seeds above 9 wrap too).
  always_comb begin
    if (r_state == M_BIN) begin
      w_cnt_adv = (r_cnt >= 4'd9) ? 4'd0 : (r_cnt + 4'd1);
    end else begin
      w_cnt_adv = r_cnt + 4'd1;
    end
  end

  // Mode FSM with counter and prescaler; a press outranks a coincident tick.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= M_NONE;
      r_running <= 1'b0;
      r_cnt     <= 4'd0;
      r_presc   <= {PW{1'b0}};
    end else if (w_any_press) begin
      r_presc <= {PW{1'b0}};
      if (w_target == r_state) begin
        r_running <= ~r_running;
      end else begin
        r_state   <= w_target;
        r_cnt     <= i_sw;
        r_running <= 1'b0;
      end
    end else if (r_running) begin
      if (r_presc == TICK_LAST) begin
        r_presc <= {PW{1'b0}};
        r_cnt   <= w_cnt_adv;
      end else begin
        r_presc <= r_presc + {{(PW-1){1'b0}}, 1'b1};
      end
    end else begin
      r_presc <= r_presc;
    end
  end

  // Glyph generation, one cycle behind mode/counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_disp2 <= G_BLANK;
      r_disp1 <= G_BLANK;
      r_disp0 <= G_BLANK;
    end else begin
      case (r_state)
        M_BIN: begin
          r_disp2 <= G_B;
          r_disp1 <= G_BLANK;
          r_disp0 <= (r_cnt <= 4'd9) ? {1'b0, r_cnt} : G_NINE;
        end
        M_DEC: begin
          r_disp2 <= G_D;
          if (r_cnt < 4'd10) begin
            r_disp1 <= G_BLANK;
            r_disp0 <= {1'b0, r_cnt};
          end else begin
            r_disp1 <= G_ONE;
            r_disp0 <= {1'b0, r_cnt - 4'd10};
          end
        end
        M_HEX: begin
          r_disp2 <= G_H;
          r_disp1 <= G_BLANK;
          r_disp0 <= {1'b0, r_cnt};
        end
        default: begin
          r_disp2 <= G_BLANK;
          r_disp1 <= G_BLANK;
          r_disp0 <= G_BLANK;
        end
      endcase
    end
  end

  assign o_disp2   = r_disp2;
  assign o_disp1   = r_disp1;
  assign o_disp0   = r_disp0;
  assign o_mode    = r_state;
  assign o_running = r_running;

endmodule

// File: tb/tb_conv_counter_ctrl.sv
// Directed bench for conv_counter_ctrl with DB_CYCLES=4, TICK_DIV=8.
// Inputs are driven and outputs sampled on the falling clock edge. A button
// driven low at falling edge t0 yields its press event on the 6th rising edge
// after t0 (2 sync flops + 4 stable cycles).

module tb_conv_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] btn = 3'b111;
  logic [3:0] sw  = 4'd0;
  logic [4:0] disp2, disp1, disp0;
  logic [1:0] mode;
  logic       running;

  int checks   = 0;
  int failures = 0;

  localparam logic [4:0] BL = 5'b10001;
  localparam logic [4:0] GB = 5'b01011;
  localparam logic [4:0] GD = 5'b01101;
  localparam logic [4:0] GH = 5'b10000;

  conv_counter_ctrl #(.DB_CYCLES(4), .TICK_DIV(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_btn(btn), .i_sw(sw),
    .o_disp2(disp2), .o_disp1(disp1), .o_disp0(disp0),
    .o_mode(mode), .o_running(running)
  );

  always #5 clk = ~clk;

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold the masked buttons low for 10 cycles, then release and let the
  // debouncers settle back to released.
  task automatic press(input logic [2:0] mask);
    btn = ~mask;
    wait_neg(10);
    btn = 3'b111;
    wait_neg(8);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wait_neg(3);
    rst = 1'b0;
    wait_neg(20);
    checks++; if (mode !== 2'd0) begin failures++; $display("FAIL reset_mode: got %0d expected 0", mode); end
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running: got %0d expected 0", running); end
    checks++; if ({disp2, disp1, disp0} !== {BL, BL, BL}) begin failures++; $display("FAIL reset_disp: got %b/%b/%b expected 10001/10001/10001", disp2, disp1, disp0); end
    // 3-cycle glitch is shorter than the debounce window
    btn = 3'b101;
    wait_neg(3);
    btn = 3'b111;
    wait_neg(10);
    checks++; if (mode !== 2'd0) begin failures++; $display("FAIL glitch_mode: got %0d expected 0", mode); end
    checks++; if (disp2 !== BL) begin failures++; $display("FAIL glitch_disp2: got %b expected 10001", disp2); end
  endtask

  task automatic test_dec_seed;
    sw = 4'd12;
    press(3'b010);
    checks++; if (mode !== 2'd2) begin failures++; $display("FAIL dec_mode: got %0d expected 2", mode); end
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL dec_running: got %0d expected 0", running); end
    checks++; if ({disp2, disp1, disp0} !== {GD, 5'b00001, 5'b00010}) begin failures++; $display("FAIL dec_disp: got %b/%b/%b expected 01101/00001/00010", disp2, disp1, disp0); end
    sw = 4'd3;
    wait_neg(10);
    checks++; if ({mode, disp1, disp0} !== {2'd2, 5'b00001, 5'b00010}) begin failures++; $display("FAIL dec_sw_ignored: got %0d %b/%b expected 2 00001/00010", mode, disp1, disp0); end
  endtask

  task automatic test_dec_run;
    btn = 3'b101;                      // t0: start edge at rising edge 6
    wait_neg(8);
    btn = 3'b111;
    wait_neg(6);                       // t14: tick happened, display not yet
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL run_start: got %0d expected 1", running); end
    checks++; if (disp0 !== 5'd2) begin failures++; $display("FAIL run_pre_tick: got %0d expected 2", disp0); end
    wait_neg(1);                       // t15
    checks++; if ({disp1, disp0} !== {5'd1, 5'd3}) begin failures++; $display("FAIL run_tick1: got %0d/%0d expected 1/3", disp1, disp0); end
    wait_neg(8);                       // t23
    checks++; if (disp0 !== 5'd4) begin failures++; $display("FAIL run_tick2: got %0d expected 4", disp0); end
    wait_neg(8);                       // t31
    checks++; if (disp0 !== 5'd5) begin failures++; $display("FAIL run_tick3: got %0d expected 5", disp0); end
    wait_neg(8);                       // t39: 15 -> 0
    checks++; if ({disp2, disp1, disp0} !== {GD, BL, 5'd0}) begin failures++; $display("FAIL run_wrap: got %b/%b/%b expected 01101/10001/00000", disp2, disp1, disp0); end
    wait_neg(1);                       // t40: stop press lands on tick edge 46
    btn = 3'b101;
    wait_neg(8);
    btn = 3'b111;
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL stop_running: got %0d expected 0", running); end
    checks++; if (disp0 !== 5'd0) begin failures++; $display("FAIL stop_tick_dropped: got %0d expected 0", disp0); end
    wait_neg(20);
    checks++; if ({mode, disp0} !== {2'd2, 5'd0}) begin failures++; $display("FAIL stop_frozen: got %0d/%0d expected 2/0", mode, disp0); end
  endtask

  task automatic test_bin;
    sw = 4'd7;
    press(3'b001);
    checks++; if (mode !== 2'd1) begin failures++; $display("FAIL bin_mode: got %0d expected 1", mode); end
    checks++; if ({disp2, disp1, disp0} !== {GB, BL, 5'd7}) begin failures++; $display("FAIL bin_disp: got %b/%b/%b expected 01011/10001/00111", disp2, disp1, disp0); end
    btn = 3'b110;
    wait_neg(8);
    btn = 3'b111;
    wait_neg(7);                       // t15
    checks++; if (disp0 !== 5'd8) begin failures++; $display("FAIL bin_tick1: got %0d expected 8", disp0); end
    wait_neg(8);
    checks++; if (disp0 !== 5'd9) begin failures++; $display("FAIL bin_tick2: got %0d expected 9", disp0); end
    wait_neg(8);
    checks++; if ({disp1, disp0} !== {BL, 5'd0}) begin failures++; $display("FAIL bin_wrap: got %b/%0d expected 10001/0", disp1, disp0); end
    // seed 13 in DEC first, then move to BIN to re-seed with 13
    sw = 4'd13;
    press(3'b010);
    checks++; if ({mode, disp1, disp0} !== {2'd2, 5'd1, 5'd3}) begin failures++; $display("FAIL dec13_disp: got %0d %0d/%0d expected 2 1/3", mode, disp1, disp0); end
    press(3'b001);
    checks++; if ({mode, disp0} !== {2'd1, 5'd9}) begin failures++; $display("FAIL bin13_clamp: got %0d/%0d expected 1/9", mode, disp0); end
    btn = 3'b110;
    wait_neg(8);
    btn = 3'b111;
    wait_neg(6);                       // t14
    checks++; if (disp0 !== 5'd9) begin failures++; $display("FAIL bin13_pre_tick: got %0d expected 9", disp0); end
    wait_neg(1);                       // t15
    checks++; if (disp0 !== 5'd0) begin failures++; $display("FAIL bin13_wrap: got %0d expected 0", disp0); end
  endtask

  task automatic test_simultaneous;
    sw = 4'd2;
    press(3'b010);
    checks++; if ({mode, disp1, disp0} !== {2'd2, BL, 5'd2}) begin failures++; $display("FAIL sim_dec_seed: got %0d %b/%0d expected 2 10001/2", mode, disp1, disp0); end
    btn = 3'b101;
    wait_neg(8);
    btn = 3'b111;
    wait_neg(7);                       // t15
    checks++; if (disp0 !== 5'd3) begin failures++; $display("FAIL sim_dec_tick: got %0d expected 3", disp0); end
    sw = 4'd5;
    wait_neg(1);                       // t16: BIN+HEX, events on tick edge 22
    btn = 3'b010;
    wait_neg(6);
    checks++; if ({mode, running} !== {2'd3, 1'b0}) begin failures++; $display("FAIL sim_mode: got %0d/%0d expected 3/0", mode, running); end
    wait_neg(1);
    checks++; if ({disp2, disp1, disp0} !== {GH, BL, 5'd5}) begin failures++; $display("FAIL sim_disp: got %b/%b/%b expected 10000/10001/00101", disp2, disp1, disp0); end
    wait_neg(1);
    btn = 3'b111;
    wait_neg(20);
    checks++; if ({mode, running, disp0} !== {2'd3, 1'b0, 5'd5}) begin failures++; $display("FAIL sim_hold: got %0d/%0d/%0d expected 3/0/5", mode, running, disp0); end
  endtask

  task automatic test_reset_mid;
    btn = 3'b011;
    wait_neg(8);
    btn = 3'b111;
    wait_neg(2);                       // t10
    checks++; if ({mode, running, disp0} !== {2'd3, 1'b1, 5'd5}) begin failures++; $display("FAIL hex_run: got %0d/%0d/%0d expected 3/1/5", mode, running, disp0); end
    wait_neg(2);
    rst = 1'b1;
    btn = 3'b011;
    wait_neg(1);
    checks++; if ({mode, running} !== {2'd0, 1'b0}) begin failures++; $display("FAIL rst_state: got %0d/%0d expected 0/0", mode, running); end
    checks++; if ({disp2, disp1, disp0} !== {BL, BL, BL}) begin failures++; $display("FAIL rst_disp: got %b/%b/%b expected blanks", disp2, disp1, disp0); end
    wait_neg(2);
    rst = 1'b0;
    wait_neg(5);
    checks++; if (mode !== 2'd0) begin failures++; $display("FAIL rst_held_early: got %0d expected 0", mode); end
    wait_neg(1);
    checks++; if (mode !== 2'd3) begin failures++; $display("FAIL rst_held_press: got %0d expected 3", mode); end
    wait_neg(1);
    checks++; if ({disp2, disp0, running} !== {GH, 5'd5, 1'b0}) begin failures++; $display("FAIL rst_held_disp: got %b/%0d/%0d expected 10000/5/0", disp2, disp0, running); end
    btn = 3'b111;
    wait_neg(10);
  endtask

  initial begin
    test_reset;
    test_dec_seed;
    test_dec_run;
    test_bin;
    test_simultaneous;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
